fp_add_arbiter: RTL and testbench



---
 rtl/fp_add_arbiter.sv | 153 +++++++++++++++
 tb/tb_fp_add_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// -----------------------------------------------------------------------------
// fp_add_arbiter
//
// Shares one external combinational float adder between two AXI4-Stream
// operand sources. A whole operand pair {A, B} is accepted from the winning
// requester, held in registers that drive the adder, and the sum is captured
// one cycle later. The sum is returned on a single AXI4-Stream master port,
// tagged with the ID of the requester that issued it. Per-requester grant
// counters are kept for debug visibility and wrap modulo 2^CNT_W.
//
// Build option:
//   FP_ARB_FIXED_PRIO_EN  defined   -> requester 0 always wins contention
//                         undefined -> round-robin on the last granted ID
//
// Ports:
//   axis_clk, axis_reset        clock, asynchronous active-low reset
//   s0_axis_valid/ready/data    requester 0 operand pair {A, B}
//   s1_axis_valid/ready/data    requester 1 operand pair {A, B}
//   add_a, add_b                registered operands to the adder
//   add_sum                     combinational sum from the adder
//   m_axis_valid/ready/data     registered result stream
//   m_axis_id                   requester that issued the result
//   gnt_cnt0, gnt_cnt1          accepted-pair counters per requester
// -----------------------------------------------------------------------------
module fp_add_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                axis_clk,
    input  logic                axis_reset,
    input  logic                s0_axis_valid,
    output logic                s0_axis_ready,
    input  logic [2*DATA_W-1:0] s0_axis_data,
    input  logic                s1_axis_valid,
    output logic                s1_axis_ready,
    input  logic [2*DATA_W-1:0] s1_axis_data,
    output logic [DATA_W-1:0]   add_a,
    output logic [DATA_W-1:0]   add_b,
    input  logic [DATA_W-1:0]   add_sum,
    output logic                m_axis_valid,
    input  logic                m_axis_ready,
    output logic [DATA_W-1:0]   m_axis_data,
    output logic                m_axis_id,
    output logic [CNT_W-1:0]    gnt_cnt0,
    output logic [CNT_W-1:0]    gnt_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state;
    logic [DATA_W-1:0]   opa_p0;
    logic [DATA_W-1:0]   opb_p0;
    logic                id_p0;
    logic [DATA_W-1:0]   sum_p1;
    logic                vld_p1;
    logic [CNT_W-1:0]    cnt0;
    logic [CNT_W-1:0]    cnt1;

    logic                pick1;
    logic                grant_en;
    logic                accept;
    logic [2*DATA_W-1:0] win_data;

    // Grant counters simply wrap; no saturation.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return c + CNT_ONE;
    endfunction

`ifdef FP_ARB_FIXED_PRIO_EN
    // Requester 1 wins only when requester 0 is idle.
    assign pick1 = ~s0_axis_valid;
`else
    logic last_gnt;
    // Requester 1 wins when it is alone, or on contention if requester 0
    // was the last one granted.
    assign pick1 = s1_axis_valid & (~s0_axis_valid | ~last_gnt);
`endif

    // Readies are a function of state and the valids only, never of
    // m_axis_ready; they are forced low while reset is held.
    assign grant_en      = axis_reset & (state == IDLE) & (s0_axis_valid | s1_axis_valid);
    assign s0_axis_ready = grant_en & ~pick1;
    assign s1_axis_ready = grant_en &  pick1;
    assign accept        = s0_axis_ready | s1_axis_ready;
    assign win_data      = pick1 ? s1_axis_data : s0_axis_data;

    always_ff @(posedge axis_clk or negedge axis_reset) begin
        if (!axis_reset) begin
            state  <= IDLE;
            opa_p0 <= '0;
            opb_p0 <= '0;
            id_p0  <= 1'b0;
            sum_p1 <= '0;
            vld_p1 <= 1'b0;
            cnt0   <= '0;
            cnt1   <= '0;
`ifndef FP_ARB_FIXED_PRIO_EN
            last_gnt <= 1'b1;
`endif
        end else begin
            case (state)
                // Stage 0: accept a pair and present it to the adder
                IDLE: begin
                    if (accept) begin
                        opa_p0 <= win_data[2*DATA_W-1:DATA_W];
                        opb_p0 <= win_data[DATA_W-1:0];
                        id_p0  <= pick1;
                        if (pick1) begin
                            cnt1 <= cnt_inc(cnt1);
                        end else begin
                            cnt0 <= cnt_inc(cnt0);
                        end
`ifndef FP_ARB_FIXED_PRIO_EN
                        last_gnt <= pick1;
`endif
                        state <= CALC;
                    end
                end
                // Stage 1: adder has settled, capture the sum
                CALC: begin
                    sum_p1 <= add_sum;
                    vld_p1 <= 1'b1;
                    state  <= OUT;
                end
                OUT: begin
                    if (m_axis_ready) begin
                        vld_p1 <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    vld_p1 <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign add_a        = opa_p0;
    assign add_b        = opb_p0;
    assign m_axis_valid = vld_p1;
    assign m_axis_data  = sum_p1;
    assign m_axis_id    = id_p0;
    assign gnt_cnt0     = cnt0;
    assign gnt_cnt1     = cnt1;

endmodule

// File: tb/tb_fp_add_arbiter.sv
module tb_fp_add_arbiter;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

`ifdef FP_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    logic                axis_clk = 1'b0;
    logic                axis_reset;
    logic                s0_axis_valid, s0_axis_ready;
    logic [2*DATA_W-1:0] s0_axis_data;
    logic                s1_axis_valid, s1_axis_ready;
    logic [2*DATA_W-1:0] s1_axis_data;
    logic [DATA_W-1:0]   add_a, add_b, add_sum;
    logic                m_axis_valid, m_axis_ready;
    logic [DATA_W-1:0]   m_axis_data;
    logic                m_axis_id;
    logic [CNT_W-1:0]    gnt_cnt0, gnt_cnt1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [DATA_W:0] sb[$];

    always #5 axis_clk = ~axis_clk;
    always @(posedge axis_clk) cyc <= cyc + 1;

    // Reference float adder for positive normal operands, truncating.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [7:0]  e, d;
        logic [24:0] mx, my, s;
        if (a[30:23] < b[30:23]) begin x = b; y = a; end
        else begin x = a; y = b; end
        e  = x[30:23];
        d  = x[30:23] - y[30:23];
        mx = {2'b01, x[22:0]};
        my = (d > 8'd24) ? 25'd0 : ({2'b01, y[22:0]} >> d);
        s  = mx + my;
        if (s[24]) begin s = s >> 1; e = e + 8'd1; end
        return s[23] ? {x[31] & y[31], e, s[22:0]} : 32'h0;
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'b0, 8'(120 + $urandom_range(0, 15)), 23'($urandom)};
    endfunction

    assign add_sum = fadd(add_a, add_b);

    fp_add_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .axis_clk      (axis_clk),
        .axis_reset    (axis_reset),
        .s0_axis_valid (s0_axis_valid),
        .s0_axis_ready (s0_axis_ready),
        .s0_axis_data  (s0_axis_data),
        .s1_axis_valid (s1_axis_valid),
        .s1_axis_ready (s1_axis_ready),
        .s1_axis_data  (s1_axis_data),
        .add_a         (add_a),
        .add_b         (add_b),
        .add_sum       (add_sum),
        .m_axis_valid  (m_axis_valid),
        .m_axis_ready  (m_axis_ready),
        .m_axis_data   (m_axis_data),
        .m_axis_id     (m_axis_id),
        .gnt_cnt0      (gnt_cnt0),
        .gnt_cnt1      (gnt_cnt1)
    );

    // Result scoreboard: every completed result handshake pops one entry.
    always @(negedge axis_clk) begin
        if (axis_reset && m_axis_valid && m_axis_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got id=%0d data=%h, required no result", m_axis_id, m_axis_data);
            end else begin
                logic [DATA_W:0] exp;
                exp = sb.pop_front();
                if ({m_axis_id, m_axis_data} !== exp) begin
                    errors++;
                    $display("FAIL sb_result: got id=%0d data=%h, required id=%0d data=%h",
                             m_axis_id, m_axis_data, exp[DATA_W], exp[DATA_W-1:0]);
                end
            end
        end
    end

    task automatic do_reset();
        axis_reset = 1'b0; s0_axis_valid = 1'b0; s1_axis_valid = 1'b0;
        sb.delete();
        repeat (2) @(posedge axis_clk);
        #1 axis_reset = 1'b1;
    endtask

    task automatic send(input logic id, input logic [63:0] pair, input logic [31:0] exp);
        int n;
        logic rdy;
        if (id) begin s1_axis_data = pair; s1_axis_valid = 1'b1; end
        else    begin s0_axis_data = pair; s0_axis_valid = 1'b1; end
        n = 0;
        forever begin
            @(negedge axis_clk);
            rdy = id ? s1_axis_ready : s0_axis_ready;
            if (rdy || n >= 40) break;
            n++;
        end
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL send_timeout id=%0d: ready got 0, required 1 within 40 cycles", id);
        end else begin
            sb.push_back({id, exp});
        end
        @(posedge axis_clk); #1;
        if (id) s1_axis_valid = 1'b0; else s0_axis_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin @(negedge axis_clk); n++; end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d results pending, required 0", sb.size());
            sb.delete();
        end
        @(posedge axis_clk); #1;
    endtask

    task automatic test_reset();
        axis_reset = 1'b0; m_axis_ready = 1'b1;
        s0_axis_valid = 1'b1; s1_axis_valid = 1'b1;
        s0_axis_data = {32'h3F800000, 32'h40000000}; s1_axis_data = s0_axis_data;
        repeat (2) @(posedge axis_clk);
        @(negedge axis_clk);
        checks++; if (s0_axis_ready !== 1'b0) begin errors++; $display("FAIL reset_s0_ready: got %b, required 0", s0_axis_ready); end
        checks++; if (s1_axis_ready !== 1'b0) begin errors++; $display("FAIL reset_s1_ready: got %b, required 0", s1_axis_ready); end
        checks++; if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b, required 0", m_axis_valid); end
        checks++; if (m_axis_data !== 32'h0) begin errors++; $display("FAIL reset_m_data: got %h, required 0", m_axis_data); end
        checks++; if (m_axis_id !== 1'b0) begin errors++; $display("FAIL reset_m_id: got %b, required 0", m_axis_id); end
        checks++; if ({add_a, add_b} !== 64'h0) begin errors++; $display("FAIL reset_add_ab: got %h, required 0", {add_a, add_b}); end
        checks++; if (gnt_cnt0 !== '0) begin errors++; $display("FAIL reset_cnt0: got %0d, required 0", gnt_cnt0); end
        checks++; if (gnt_cnt1 !== '0) begin errors++; $display("FAIL reset_cnt1: got %0d, required 0", gnt_cnt1); end
        @(posedge axis_clk); #1;
        s0_axis_valid = 1'b0; s1_axis_valid = 1'b0; axis_reset = 1'b1;
    endtask

    task automatic test_single();
        m_axis_ready = 1'b1;
        s0_axis_data = {32'h3F800000, 32'h40000000}; s0_axis_valid = 1'b1;
        @(negedge axis_clk);
        checks++; if ({s1_axis_ready, s0_axis_ready} !== 2'b01) begin errors++; $display("FAIL single_ready: got %b, required 01", {s1_axis_ready, s0_axis_ready}); end
        sb.push_back({1'b0, 32'h40400000});
        @(posedge axis_clk); #1 s0_axis_valid = 1'b0;
        @(negedge axis_clk);
        checks++; if ({add_a, add_b} !== 64'h3F800000_40000000) begin errors++; $display("FAIL single_operands: got %h, required 3f80000040000000", {add_a, add_b}); end
        checks++; if (gnt_cnt0 !== 8'd1) begin errors++; $display("FAIL single_cnt0: got %0d, required 1", gnt_cnt0); end
        checks++; if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early: got %b, required 0", m_axis_valid); end
        @(negedge axis_clk);
        checks++; if ({m_axis_valid, m_axis_id, m_axis_data} !== {2'b10, 32'h40400000}) begin errors++; $display("FAIL single_result: got v=%b id=%b d=%h, required v=1 id=0 d=40400000", m_axis_valid, m_axis_id, m_axis_data); end
        @(negedge axis_clk);
        checks++; if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL single_valid_clear: got %b, required 0", m_axis_valid); end
        drain();
    endtask

    task automatic test_contention();
        logic [1:0] rdy;
        logic       exp_id;
        int         n, last_acc;
        do_reset();
        m_axis_ready = 1'b1;
        s0_axis_data = {rand_fp(), rand_fp()}; s1_axis_data = {rand_fp(), rand_fp()};
        s0_axis_valid = 1'b1; s1_axis_valid = 1'b1;
        last_acc = 0;
        for (int t = 0; t < 4; t++) begin
            exp_id = FIXED_PRIO ? 1'b0 : t[0];
            n = 0;
            @(negedge axis_clk);
            while (!(s0_axis_ready || s1_axis_ready) && n < 20) begin @(negedge axis_clk); n++; end
            rdy = {s1_axis_ready, s0_axis_ready};
            checks++;
            if (rdy !== (exp_id ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL contention_grant%0d: got readies %b, required id %0d", t, rdy, exp_id);
            end
            sb.push_back({exp_id, exp_id ? fadd(s1_axis_data[63:32], s1_axis_data[31:0])
                                         : fadd(s0_axis_data[63:32], s0_axis_data[31:0])});
            if (t > 0) begin
                checks++;
                if (cyc - last_acc !== 3) begin errors++; $display("FAIL issue_interval: got %0d, required 3", cyc - last_acc); end
            end
            last_acc = cyc;
            @(posedge axis_clk); #1;
            if (rdy[1]) s1_axis_data = {rand_fp(), rand_fp()};
            if (rdy[0]) s0_axis_data = {rand_fp(), rand_fp()};
        end
        s0_axis_valid = 1'b0; s1_axis_valid = 1'b0;
        drain();
        checks++; if (gnt_cnt0 !== (FIXED_PRIO ? 8'd4 : 8'd2)) begin errors++; $display("FAIL contention_cnt0: got %0d", gnt_cnt0); end
        checks++; if (gnt_cnt1 !== (FIXED_PRIO ? 8'd0 : 8'd2)) begin errors++; $display("FAIL contention_cnt1: got %0d", gnt_cnt1); end
    endtask

    task automatic test_backpressure();
        logic [63:0]      p;
        logic [31:0]      exp;
        logic [CNT_W-1:0] c0, c1;
        m_axis_ready = 1'b0;
        p = {rand_fp(), rand_fp()};
        exp = fadd(p[63:32], p[31:0]);
        send(1'b1, p, exp);
        c0 = gnt_cnt0; c1 = gnt_cnt1;
        s0_axis_data = {rand_fp(), rand_fp()}; s1_axis_data = {rand_fp(), rand_fp()};
        s0_axis_valid = 1'b1; s1_axis_valid = 1'b1;
        @(posedge axis_clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge axis_clk);
            checks++; if (m_axis_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d: got %b, required 1", i, m_axis_valid); end
            checks++; if ({m_axis_id, m_axis_data} !== {1'b1, exp}) begin errors++; $display("FAIL bp_hold%0d: got id=%b d=%h, required id=1 d=%h", i, m_axis_id, m_axis_data, exp); end
            checks++; if ({s1_axis_ready, s0_axis_ready} !== 2'b00) begin errors++; $display("FAIL bp_readies%0d: got %b, required 00", i, {s1_axis_ready, s0_axis_ready}); end
            checks++; if ({add_a, add_b} !== p) begin errors++; $display("FAIL bp_operands%0d: got %h, required %h", i, {add_a, add_b}, p); end
        end
        @(posedge axis_clk); #1;
        m_axis_ready = 1'b1; s0_axis_valid = 1'b0; s1_axis_valid = 1'b0;
        @(posedge axis_clk);
        repeat (3) @(negedge axis_clk);
        checks++; if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b, required 0", m_axis_valid); end
        checks++; if ({gnt_cnt0, gnt_cnt1} !== {c0, c1}) begin errors++; $display("FAIL bp_withdrawn_counted: got %0d/%0d, required %0d/%0d", gnt_cnt0, gnt_cnt1, c0, c1); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL bp_results_pending: got %0d, required 0", sb.size()); end
        @(posedge axis_clk); #1;
    endtask

    task automatic test_swap();
        m_axis_ready = 1'b1;
        send(1'b1, {32'h3FC00000, 32'h3FC00000}, 32'h40400000);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [63:0] p;
        m_axis_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            p = {rand_fp(), rand_fp()};
            send(i[0], p, fadd(p[63:32], p[31:0]));
        end
        drain();
    endtask

    task automatic test_wrap();
        logic [63:0] p;
        do_reset();
        m_axis_ready = 1'b1;
        for (int i = 0; i < (1 << CNT_W); i++) begin
            p = {rand_fp(), rand_fp()};
            send(1'b1, p, fadd(p[63:32], p[31:0]));
            if (i == (1 << CNT_W) - 2) begin
                checks++; if (gnt_cnt1 !== {CNT_W{1'b1}}) begin errors++; $display("FAIL wrap_max: got %h, required all ones", gnt_cnt1); end
            end
        end
        drain();
        checks++; if (gnt_cnt1 !== '0) begin errors++; $display("FAIL wrap_zero: got %h, required 0", gnt_cnt1); end
        checks++; if (gnt_cnt0 !== '0) begin errors++; $display("FAIL wrap_cnt0: got %h, required 0", gnt_cnt0); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] p;
        m_axis_ready = 1'b1;
        p = {rand_fp(), rand_fp()};
        send(1'b0, p, fadd(p[63:32], p[31:0]));
        // Now in CALC: reset discards the in-flight pair.
        axis_reset = 1'b0;
        s0_axis_data = {rand_fp(), rand_fp()}; s1_axis_data = {rand_fp(), rand_fp()};
        s0_axis_valid = 1'b1; s1_axis_valid = 1'b1;
        sb.delete();
        #1;
        checks++; if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b, required 0", m_axis_valid); end
        checks++; if ({s1_axis_ready, s0_axis_ready} !== 2'b00) begin errors++; $display("FAIL midrst_readies: got %b, required 00", {s1_axis_ready, s0_axis_ready}); end
        checks++; if ({add_a, add_b} !== 64'h0) begin errors++; $display("FAIL midrst_operands: got %h, required 0", {add_a, add_b}); end
        repeat (2) @(posedge axis_clk);
        #1 axis_reset = 1'b1;
        @(negedge axis_clk);
        checks++; if ({s1_axis_ready, s0_axis_ready} !== 2'b01) begin errors++; $display("FAIL midrst_rearb: got %b, required 01", {s1_axis_ready, s0_axis_ready}); end
        sb.push_back({1'b0, fadd(s0_axis_data[63:32], s0_axis_data[31:0])});
        @(posedge axis_clk); #1;
        s0_axis_valid = 1'b0; s1_axis_valid = 1'b0;
        drain();
        checks++; if ({gnt_cnt0, gnt_cnt1} !== {8'd1, 8'd0}) begin errors++; $display("FAIL midrst_counts: got %0d/%0d, required 1/0", gnt_cnt0, gnt_cnt1); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_swap();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
